// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between port A (CPU) and
// port B (debug/DMA) with a req/gnt handshake and round-robin tie-breaking.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port A always wins a tie.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    state_t state;
    logic   last_b;   // 1: port B received the most recent grant
    logic   win_b;    // port owning the access in flight
    logic   pick_b;   // arbitration result for the current IDLE cycle

    // Read data comes straight from the memory's output register
    assign rdata = mem_rdata;

    // B wins when alone, or on a tie when A was served last (round-robin only)
    always_comb begin
        pick_b = req_b && (!req_a || (!FIXED_PRIO && !last_b));
    end

    // Arbiter FSM; every output except rdata is a register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_b    <= 1'b1;
            win_b     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        win_b     <= pick_b;
                        last_b    <= pick_b;
                        gnt_a     <= !pick_b;
                        gnt_b     <= pick_b;
                        mem_addr  <= pick_b ? addr_b  : addr_a;
                        mem_wdata <= pick_b ? wdata_b : wdata_a;
                        mem_rw    <= pick_b ? !we_b   : !we_a;
                        state     <= ACCESS;
                    end else begin
                        mem_rw <= 1'b1;
                    end
                end
                ACCESS: begin
                    // mem_rw still reflects the operation performed at this edge
                    gnt_a  <= 1'b0;
                    gnt_b  <= 1'b0;
                    mem_rw <= 1'b1;
                    if (mem_rw) begin
                        rvalid_a <= !win_b;
                        rvalid_b <= win_b;
                        state    <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    rvalid_a <= 1'b0;
                    rvalid_b <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed vector table plus hand-written corner sequences
// for data_mem_arbiter, with a behavioural single-port memory attached.
module tb_data_mem_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_rdata;

    // Memory model plus a side door used to preload contents
    logic [DATA_W-1:0] mem [4096];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;
    int                wr_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .gnt_a     (gnt_a),
        .rvalid_a  (rvalid_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .gnt_b     (gnt_b),
        .rvalid_b  (rvalid_b),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory: writes on every edge with RW=0, registered read
    always @(posedge clock) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!mem_rw) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
        if (mem_rw) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic              port;   // 0 = A, 1 = B
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One complete transaction, entered and left at a negedge in IDLE
    task automatic do_txn(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp);
        if (!port) begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
        end else begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
        end
        @(negedge clock);
        chk("txn_gnt_a", 32'(gnt_a), 32'(!port));
        chk("txn_gnt_b", 32'(gnt_b), 32'(port));
        chk("txn_mem_rw", 32'(mem_rw), 32'(!we));
        chk("txn_mem_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("txn_mem_wdata", 32'(mem_wdata), 32'(wdata));
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clock);
        chk("txn_gnt_clr", 32'({gnt_a, gnt_b}), 32'(0));
        chk("txn_rw_idle", 32'(mem_rw), 32'(1));
        if (!we) begin
            chk("txn_rvalid_a", 32'(rvalid_a), 32'(!port));
            chk("txn_rvalid_b", 32'(rvalid_b), 32'(port));
            chk("txn_rdata", 32'(rdata), 32'(exp));
            @(negedge clock);
            chk("txn_rvalid_clr", 32'({rvalid_a, rvalid_b}), 32'(0));
        end else begin
            chk("txn_no_rvalid", 32'({rvalid_a, rvalid_b}), 32'(0));
        end
    endtask

    initial begin
        int snap;
        logic exp_b;
        vecs[0] = '{1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 12'hFFF, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b1, 12'h010, 16'h5A5A, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'h0F0F};
        vecs[6] = '{1'b0, 1'b1, 12'h000, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'hFFFF};

        reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0; wr_count = 0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        do_reset();

        // Reset values
        chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'(0));
        chk("rst_rvalid", 32'({rvalid_a, rvalid_b}), 32'(0));
        chk("rst_mem_rw", 32'(mem_rw), 32'(1));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));

        preload(12'h005, 16'h1234);
        preload(12'h000, 16'h0F0F);
        preload(12'h020, 16'h2020);
        preload(12'h100, 16'h1111);
        preload(12'h200, 16'h2222);

        // Vector table: single-port transactions
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Idle with noisy inputs: memory must never be written
        snap = wr_count;
        for (int i = 0; i < 20; i++) begin
            addr_a = 12'($urandom); wdata_a = 16'($urandom); we_a = 1'($urandom);
            addr_b = 12'($urandom); wdata_b = 16'($urandom); we_b = 1'($urandom);
            @(negedge clock);
            chk("idle_mem_rw", 32'(mem_rw), 32'(1));
        end
        chk("idle_wr_count", 32'(wr_count), 32'(snap));
        do_txn(1'b1, 1'b0, 12'h005, 16'h0000, 16'h1234);

        // Both ports requesting continuously, starting fresh from reset
        do_reset();
        req_a = 1'b1; we_a = 1'b0; addr_a = 12'h100;
        req_b = 1'b1; we_b = 1'b0; addr_b = 12'h200;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_b = 1'b0;
`else
            exp_b = 1'(k % 2);
`endif
            @(negedge clock);
            chk("alt_gnt", 32'({gnt_a, gnt_b}), exp_b ? 32'(1) : 32'(2));
            @(negedge clock);
            chk("alt_rvalid", 32'({rvalid_a, rvalid_b}), exp_b ? 32'(1) : 32'(2));
            chk("alt_rdata", 32'(rdata), exp_b ? 32'(16'h2222) : 32'(16'h1111));
            @(negedge clock);
            chk("alt_idle", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 32'(0));
        end
        req_a = 1'b0; req_b = 1'b0;

        // Reset during the ACCESS cycle of a port A read
        req_a = 1'b1; we_a = 1'b0; addr_a = 12'h005;
        @(negedge clock);
        chk("rstacc_gnt_a", 32'(gnt_a), 32'(1));
        req_a = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstacc_rvalid", 32'({rvalid_a, rvalid_b}), 32'(0));
        chk("rstacc_mem_rw", 32'(mem_rw), 32'(1));
        chk("rstacc_gnt", 32'({gnt_a, gnt_b}), 32'(0));
        @(negedge clock);
        chk("rstacc_rvalid2", 32'({rvalid_a, rvalid_b}), 32'(0));
        do_txn(1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234);

        // req_b rises during port A's RESP cycle
        req_a = 1'b1; we_a = 1'b0; addr_a = 12'h020;
        @(negedge clock);
        chk("late_gnt_a", 32'(gnt_a), 32'(1));
        req_a = 1'b0;
        @(negedge clock);
        chk("late_rvalid_a", 32'({rvalid_a, rvalid_b}), 32'(2));
        chk("late_rdata_a", 32'(rdata), 32'(16'h2020));
        req_b = 1'b1; we_b = 1'b0; addr_b = 12'h005;
        @(negedge clock);
        chk("late_idle", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 32'(0));
        @(negedge clock);
        chk("late_gnt_b", 32'({gnt_a, gnt_b}), 32'(1));
        req_b = 1'b0;
        @(negedge clock);
        chk("late_rvalid_b", 32'({rvalid_a, rvalid_b}), 32'(1));
        chk("late_rdata_b", 32'(rdata), 32'(16'h1234));
        @(negedge clock);
        chk("late_done", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Mutual exclusion and no-spurious-write invariants, checked every cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (gnt_a && gnt_b) begin
                errors++;
                $display("FAIL excl_gnt: both gnt high at %0t", $time);
            end
            if (rvalid_a && rvalid_b) begin
                errors++;
                $display("FAIL excl_rvalid: both rvalid high at %0t", $time);
            end
            if (!mem_rw && !gnt_a && !gnt_b) begin
                errors++;
                $display("FAIL spurious_write: mem_rw=0 outside a grant cycle at %0t", $time);
            end
        end
    end

endmodule
